// File: rtl/ffs_pkg.sv
// Widths shared between the vector packer and the 1024-bit find-first-set pipeline.
package ffs_pkg;

   localparam int FFS_VEC_W  = 1024;
   localparam int FFS_IDX_W  = 10;
   localparam int FFS_WORD_W = 32;

   typedef enum logic {
      PK_FILL,
      PK_FULL
   } packState_e;

endpackage

// File: rtl/ffs_vector_packer.sv
// Assembles narrow input words into one wide search vector for the FFS pipeline,
// with early termination, zero fill and a single registered output slot.
module ffs_vector_packer
   import ffs_pkg::*;
#(
   parameter int  VEC_W   = FFS_VEC_W,
   parameter int  WORD_W  = FFS_WORD_W,
   localparam int N_WORDS = VEC_W / WORD_W,
   localparam int IDX_W   = $clog2(N_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [VEC_W-1:0]  out_vec,
   output logic              out_zero,
   output logic [IDX_W:0]    out_words
);

   packState_e       state_q, state_d;
   logic [VEC_W-1:0] asmVec_q, asmVec_d;
   logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
   logic             nonzero_q, nonzero_d;
   logic             inReady_q, inReady_d;
   logic [IDX_W:0]   heldWords_q, heldWords_d;
   logic             heldZero_q, heldZero_d;
   logic             outValid_q, outValid_d;
   logic [VEC_W-1:0] outVec_q, outVec_d;
   logic             outZero_q, outZero_d;
   logic [IDX_W:0]   outWords_q, outWords_d;

   logic             accept;
   logic             complete;
   logic             slotFree;
   logic             nonzeroNext;
   logic [IDX_W:0]   curWords;
   logic [VEC_W-1:0] mergedVec;

   // in_ready is gated by reset so it reads 0 during reset and 1 straight after.
   assign in_ready    = inReady_q & ~reset;
   assign accept      = in_valid & in_ready;
   assign complete    = accept & (in_last | (wordIdx_q == IDX_W'(N_WORDS - 1)));
   assign slotFree    = ~outValid_q | out_ready;
   assign nonzeroNext = nonzero_q | (|in_word);
   assign curWords    = {1'b0, wordIdx_q} + (IDX_W + 1)'(1);

   // Slots above the current index are forced to zero, so stale words never leak.
   always_comb begin
      mergedVec = '0;
      for (int j = 0; j < N_WORDS; j++) begin
         if (j < int'(wordIdx_q)) begin
            mergedVec[j*WORD_W +: WORD_W] = asmVec_q[j*WORD_W +: WORD_W];
         end else if (j == int'(wordIdx_q)) begin
            mergedVec[j*WORD_W +: WORD_W] = in_word;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      asmVec_d    = asmVec_q;
      wordIdx_d   = wordIdx_q;
      nonzero_d   = nonzero_q;
      inReady_d   = inReady_q;
      heldWords_d = heldWords_q;
      heldZero_d  = heldZero_q;
      outValid_d  = outValid_q;
      outVec_d    = outVec_q;
      outZero_d   = outZero_q;
      outWords_d  = outWords_q;
      case (state_q)
         PK_FILL: begin
            inReady_d = 1'b1;
            if (accept) begin
               asmVec_d  = mergedVec;
               wordIdx_d = wordIdx_q + 1'b1;
               nonzero_d = nonzeroNext;
            end
            if (complete) begin
               wordIdx_d = '0;
               nonzero_d = 1'b0;
               if (slotFree) begin
                  outValid_d = 1'b1;
                  outVec_d   = mergedVec;
                  outZero_d  = ~nonzeroNext;
                  outWords_d = curWords;
               end else begin
                  state_d     = PK_FULL;
                  inReady_d   = 1'b0;
                  heldWords_d = curWords;
                  heldZero_d  = ~nonzeroNext;
               end
            end else if (out_ready) begin
               outValid_d = 1'b0;
            end
         end
         PK_FULL: begin
            // The held vector lives in the assembly register until the slot drains.
            inReady_d = 1'b0;
            if (out_ready) begin
               state_d    = PK_FILL;
               outValid_d = 1'b1;
               outVec_d   = asmVec_q;
               outZero_d  = heldZero_q;
               outWords_d = heldWords_q;
            end
         end
         default: state_d = PK_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= PK_FILL;
         asmVec_q    <= '0;
         wordIdx_q   <= '0;
         nonzero_q   <= 1'b0;
         inReady_q   <= 1'b1;
         heldWords_q <= '0;
         heldZero_q  <= 1'b0;
         outValid_q  <= 1'b0;
         outVec_q    <= '0;
         outZero_q   <= 1'b0;
         outWords_q  <= '0;
      end else begin
         state_q     <= state_d;
         asmVec_q    <= asmVec_d;
         wordIdx_q   <= wordIdx_d;
         nonzero_q   <= nonzero_d;
         inReady_q   <= inReady_d;
         heldWords_q <= heldWords_d;
         heldZero_q  <= heldZero_d;
         outValid_q  <= outValid_d;
         outVec_q    <= outVec_d;
         outZero_q   <= outZero_d;
         outWords_q  <= outWords_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_vec   = outVec_q;
   assign out_zero  = outZero_q;
   assign out_words = outWords_q;

endmodule

// File: tb/tb_ffs_vector_packer.sv
// Directed bench for ffs_vector_packer: hand-computed vectors, latency, backpressure and reset.
module tb_ffs_vector_packer;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_word;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [1023:0] out_vec;
   logic          out_zero;
   logic [5:0]    out_words;

   typedef struct {
      logic [1023:0] vec;
      logic          zero;
      logic [5:0]    words;
      int            cyc;
   } entry_t;

   entry_t        xferQ[$];
   int            cycleCnt = 0;
   int            lastAcceptCyc = 0;
   int            stallCnt = 0;
   int            errCnt = 0;
   int            checkCnt = 0;
   entry_t        e, e0, e1;
   logic [1023:0] expVec;

   ffs_vector_packer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vec   (out_vec),
      .out_zero  (out_zero),
      .out_words (out_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Every output transfer is logged with the index of the edge it happens on.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         xferQ.push_back('{vec: out_vec, zero: out_zero, words: out_words, cyc: cycleCnt + 1});
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkVec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      for (int w = 0; w < 32; w++) begin
         checkOutput($sformatf("%s[%0d]", tag, w), 64'(obs[w*32 +: 32]), 64'(exp[w*32 +: 32]));
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_word  = word;
      in_last  = last;
      if (!in_ready) stallCnt++;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) checkOutput("acceptTimeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      lastAcceptCyc = cycleCnt;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic getEntry(output entry_t ent);
      int n = 0;
      while (xferQ.size() == 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (xferQ.size() == 0) begin
         checkOutput("entryTimeout", 64'd0, 64'd1);
         ent.vec   = '1;
         ent.zero  = 1'bx;
         ent.words = '1;
         ent.cyc   = -1;
      end else begin
         ent = xferQ.pop_front();
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_word   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.outValid", 64'(out_valid), 64'd0);
      checkOutput("rst.outZero", 64'(out_zero), 64'd0);
      checkOutput("rst.outWords", 64'(out_words), 64'd0);
      checkOutput("rst.inReady", 64'(in_ready), 64'd0);
      checkVec("rst.vec", out_vec, '0);
      reset = 1'b0;
      #1;
      checkOutput("rst.inReadyAfter", 64'(in_ready), 64'd1);

      $display("[TB] single set bit at 168");
      for (int i = 0; i < 32; i++) applyStimulus((i == 5) ? 32'h0000_0100 : 32'h0, 1'b0);
      getEntry(e);
      expVec = '0;
      expVec[168] = 1'b1;
      checkVec("t1.vec", e.vec, expVec);
      checkOutput("t1.zero", 64'(e.zero), 64'd0);
      checkOutput("t1.words", 64'(e.words), 64'd32);
      checkOutput("t1.latency", 64'(e.cyc), 64'(lastAcceptCyc + 1));

      $display("[TB] early termination after 3 words");
      for (int i = 0; i < 3; i++) applyStimulus(32'hFFFF_FFFF, (i == 2));
      getEntry(e);
      expVec = '0;
      expVec[95:0] = '1;
      checkVec("t2.vec", e.vec, expVec);
      checkOutput("t2.words", 64'(e.words), 64'd3);
      checkOutput("t2.zero", 64'(e.zero), 64'd0);
      applyStimulus(32'h1234_5678, 1'b1);
      getEntry(e);
      expVec = '0;
      expVec[31:0] = 32'h1234_5678;
      checkVec("t2b.vec", e.vec, expVec);
      checkOutput("t2b.words", 64'(e.words), 64'd1);

      $display("[TB] all-zero vector");
      for (int i = 0; i < 32; i++) applyStimulus(32'h0, 1'b0);
      getEntry(e);
      checkVec("t3.vec", e.vec, '0);
      checkOutput("t3.zero", 64'(e.zero), 64'd1);
      checkOutput("t3.words", 64'(e.words), 64'd32);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(32'hAAAA_0000, 1'b0);
      applyStimulus(32'hAAAA_0001, 1'b1);
      applyStimulus(32'hBBBB_0000, 1'b0);
      applyStimulus(32'hBBBB_0001, 1'b1);
      checkOutput("t4.stallReady", 64'(in_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t4.holdValid", 64'(out_valid), 64'd1);
      checkOutput("t4.holdVec", out_vec[63:0], 64'hAAAA_0001_AAAA_0000);
      checkOutput("t4.holdWords", 64'(out_words), 64'd2);
      checkOutput("t4.noXfer", 64'(xferQ.size()), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t4.switchVec", out_vec[63:0], 64'hBBBB_0001_BBBB_0000);
      checkOutput("t4.switchValid", 64'(out_valid), 64'd1);
      checkOutput("t4.bubbleReady", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("t4.readyBack", 64'(in_ready), 64'd1);
      applyStimulus(32'hCCCC_0000, 1'b1);
      getEntry(e);
      expVec = '0;
      expVec[63:0] = 64'hAAAA_0001_AAAA_0000;
      checkVec("t4.vecA", e.vec, expVec);
      checkOutput("t4.wordsA", 64'(e.words), 64'd2);
      getEntry(e);
      expVec = '0;
      expVec[63:0] = 64'hBBBB_0001_BBBB_0000;
      checkVec("t4.vecB", e.vec, expVec);
      checkOutput("t4.wordsB", 64'(e.words), 64'd2);
      getEntry(e);
      expVec = '0;
      expVec[31:0] = 32'hCCCC_0000;
      checkVec("t4.vecC", e.vec, expVec);
      checkOutput("t4.wordsC", 64'(e.words), 64'd1);

      $display("[TB] 64 continuous words");
      xferQ.delete();
      stallCnt = 0;
      for (int i = 0; i < 64; i++) applyStimulus(32'h0000_1000 + 32'(i), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t5.stalls", 64'(stallCnt), 64'd0);
      checkOutput("t5.pulses", 64'(xferQ.size()), 64'd2);
      getEntry(e0);
      getEntry(e1);
      checkOutput("t5.spacing", 64'(e1.cyc - e0.cyc), 64'd32);
      checkOutput("t5.latency", 64'(e1.cyc), 64'(lastAcceptCyc + 1));
      checkOutput("t5.words0", 64'(e0.words), 64'd32);
      checkOutput("t5.v0first", 64'(e0.vec[31:0]), 64'h1000);
      checkOutput("t5.v0last", 64'(e0.vec[1023:992]), 64'h101F);
      checkOutput("t5.v1first", 64'(e1.vec[31:0]), 64'h1020);
      checkOutput("t5.v1last", 64'(e1.vec[1023:992]), 64'h103F);

      $display("[TB] reset mid-vector");
      xferQ.delete();
      for (int i = 0; i < 10; i++) applyStimulus(32'hDEAD_0000 + 32'(i), 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t6.rstValid", 64'(out_valid), 64'd0);
      checkOutput("t6.rstReady", 64'(in_ready), 64'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t6.postValid", 64'(out_valid), 64'd0);
      checkOutput("t6.noEmit", 64'(xferQ.size()), 64'd0);
      for (int i = 0; i < 32; i++) applyStimulus((i == 3) ? 32'h0000_0005 : 32'h0, 1'b0);
      getEntry(e);
      expVec = '0;
      expVec[98:96] = 3'b101;
      checkVec("t6.vec", e.vec, expVec);
      checkOutput("t6.words", 64'(e.words), 64'd32);
      checkOutput("t6.zero", 64'(e.zero), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t6.single", 64'(xferQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
      $finish;
   end

endmodule
